// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus PHY delay trainer: tap/length types, FSM states, train pattern.
package hyperbus_pkg;

  typedef logic [3:0] tap_t;
  typedef logic [4:0] win_len_t;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StReq,
    StWait,
    StEval,
    StFinish
  } train_state_e;

  localparam logic [15:0] TrainPatternDefault = 16'hA5C3;

  // Floor centre of a window; lo + len - 1 never exceeds 15, so no overflow.
  function automatic tap_t win_centre(tap_t lo, win_len_t len);
    win_len_t half;
    half = (len - 5'd1) >> 1;
    return lo + tap_t'(half);
  endfunction

endpackage

// File: rtl/hyperbus_train_window.sv
// Run tracker for the delay trainer: follows the current passing run and keeps the longest one.
module hyperbus_train_window
  import hyperbus_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     clear_i,
  input  logic     eval_i,
  input  logic     pass_i,
  input  tap_t     tap_i,
  output tap_t     best_lo_o,
  output win_len_t best_len_o
);

  tap_t     cur_lo_q, cur_lo_d, best_lo_q, best_lo_d;
  win_len_t cur_len_q, cur_len_d, best_len_q, best_len_d;
  tap_t     run_lo;
  win_len_t run_len;

  always_comb begin
    cur_lo_d   = cur_lo_q;
    cur_len_d  = cur_len_q;
    best_lo_d  = best_lo_q;
    best_len_d = best_len_q;
    run_lo     = (cur_len_q == '0) ? tap_i : cur_lo_q;
    run_len    = cur_len_q + 5'd1;
    if (clear_i) begin
      cur_lo_d   = '0;
      cur_len_d  = '0;
      best_lo_d  = '0;
      best_len_d = '0;
    end else if (eval_i) begin
      if (pass_i) begin
        cur_lo_d  = run_lo;
        cur_len_d = run_len;
        // Strictly greater: the earliest of equal-length windows is kept.
        if (run_len > best_len_q) begin
          best_lo_d  = run_lo;
          best_len_d = run_len;
        end
      end else begin
        cur_len_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_lo_q   <= '0;
      cur_len_q  <= '0;
      best_lo_q  <= '0;
      best_len_q <= '0;
    end else begin
      cur_lo_q   <= cur_lo_d;
      cur_len_q  <= cur_len_d;
      best_lo_q  <= best_lo_d;
      best_len_q <= best_len_d;
    end
  end

  assign best_lo_o  = best_lo_q;
  assign best_len_o = best_len_q;

endmodule

// File: rtl/hyperbus_delay_trainer.sv
// RX strobe delay trainer: sweeps all taps with test reads and programs the best window centre.
// Optional response timeout in WAIT is enabled by defining HYPERBUS_TRAIN_TIMEOUT_EN.
module hyperbus_delay_trainer
  import hyperbus_pkg::*;
#(
  parameter int unsigned          NumTaps      = 16,
  parameter int unsigned          DataWidth    = 16,
  parameter logic [DataWidth-1:0] TrainPattern = DataWidth'(TrainPatternDefault),
  parameter int unsigned          SettleCycles = 4,
  parameter logic [3:0]           DefaultDelay = 4'd8
`ifdef HYPERBUS_TRAIN_TIMEOUT_EN
  ,
  parameter int unsigned          TimeoutCycles = 64
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [3:0]           delay_o,
  output logic [3:0]           win_lo_o,
  output logic [4:0]           win_len_o,
  output logic                 test_valid_o,
  input  logic                 test_ready_i,
  input  logic                 resp_valid_i,
  input  logic [DataWidth-1:0] resp_data_i,
  input  logic                 resp_error_i
);

  localparam int unsigned SettleW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam tap_t        LastTap = tap_t'(NumTaps - 1);

  train_state_e state_q, state_d;
  tap_t         tap_q, tap_d, delay_q, delay_d, win_lo_q, win_lo_d;
  win_len_t     win_len_q, win_len_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic         test_valid_q, test_valid_d;
  logic         done_q, done_d, fail_q, fail_d, busy_q, busy_d, pass_q, pass_d;
  logic         win_clear, win_eval;
  tap_t         best_lo;
  win_len_t     best_len;

`ifdef HYPERBUS_TRAIN_TIMEOUT_EN
  localparam int unsigned ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    delay_d      = delay_q;
    settle_d     = settle_q;
    test_valid_d = test_valid_q;
    done_d       = 1'b0;
    fail_d       = fail_q;
    win_lo_d     = win_lo_q;
    win_len_d    = win_len_q;
    pass_d       = pass_q;
    win_clear    = 1'b0;
    win_eval     = (state_q == StEval);
`ifdef HYPERBUS_TRAIN_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          tap_d     = '0;
          delay_d   = '0;
          fail_d    = 1'b0;
          settle_d  = '0;
          win_clear = 1'b1;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == SettleW'(SettleCycles - 1)) begin
          settle_d = '0;
          state_d  = StReq;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      StReq: begin
        // First REQ cycle raises valid; it then holds until the handshake.
        if (!test_valid_q) begin
          test_valid_d = 1'b1;
        end else if (test_ready_i) begin
          test_valid_d = 1'b0;
          state_d      = StWait;
`ifdef HYPERBUS_TRAIN_TIMEOUT_EN
          to_cnt_d     = '0;
`endif
        end
      end
      StWait: begin
        if (resp_valid_i) begin
          pass_d  = !resp_error_i && (resp_data_i == TrainPattern);
          state_d = StEval;
        end
`ifdef HYPERBUS_TRAIN_TIMEOUT_EN
        else if (to_cnt_q == ToW'(TimeoutCycles - 1)) begin
          pass_d  = 1'b0;
          state_d = StEval;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
`endif
      end
      StEval: begin
        if (tap_q == LastTap) begin
          state_d = StFinish;
        end else begin
          tap_d    = tap_q + 4'd1;
          delay_d  = tap_q + 4'd1;
          settle_d = '0;
          state_d  = StSettle;
        end
      end
      StFinish: begin
        done_d    = 1'b1;
        win_lo_d  = best_lo;
        win_len_d = best_len;
        if (best_len == '0) begin
          fail_d  = 1'b1;
          delay_d = DefaultDelay;
        end else begin
          delay_d = win_centre(best_lo, best_len);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tap_q        <= '0;
      delay_q      <= DefaultDelay;
      settle_q     <= '0;
      test_valid_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      win_lo_q     <= '0;
      win_len_q    <= '0;
`ifdef HYPERBUS_TRAIN_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      delay_q      <= delay_d;
      settle_q     <= settle_d;
      test_valid_q <= test_valid_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      pass_q       <= pass_d;
      win_lo_q     <= win_lo_d;
      win_len_q    <= win_len_d;
`ifdef HYPERBUS_TRAIN_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  hyperbus_train_window u_window (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (win_clear),
    .eval_i     (win_eval),
    .pass_i     (pass_q),
    .tap_i      (tap_q),
    .best_lo_o  (best_lo),
    .best_len_o (best_len)
  );

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign delay_o      = delay_q;
  assign win_lo_o     = win_lo_q;
  assign win_len_o    = win_len_q;
  assign test_valid_o = test_valid_q;

endmodule

// File: tb/tb_hyperbus_delay_trainer.sv
// Directed bench for hyperbus_delay_trainer: table of pass masks with expected windows,
// plus hand sequences for ready stall, mid-run reset and (with HYPERBUS_TRAIN_TIMEOUT_EN) timeout.
module tb_hyperbus_delay_trainer;

  localparam logic [15:0] Pattern = 16'hA5C3;

  logic        clk_i, rst_ni, start_i;
  logic        busy_o, done_o, fail_o, test_valid_o;
  logic [3:0]  delay_o, win_lo_o;
  logic [4:0]  win_len_o;
  logic        test_ready_i, resp_valid_i, resp_error_i;
  logic [15:0] resp_data_i;

  hyperbus_delay_trainer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fail_o       (fail_o),
    .delay_o      (delay_o),
    .win_lo_o     (win_lo_o),
    .win_len_o    (win_len_o),
    .test_valid_o (test_valid_o),
    .test_ready_i (test_ready_i),
    .resp_valid_i (resp_valid_i),
    .resp_data_i  (resp_data_i),
    .resp_error_i (resp_error_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] mask;
    bit          use_err;
    bit          stall;
    logic [3:0]  lo;
    logic [4:0]  len;
    logic [3:0]  dly;
    bit          fail;
    int          lat;
  } vec_t;

  vec_t        vecs[9];
  int          n_checks = 0;
  int          n_err = 0;
  logic [15:0] pass_mask = 16'hFFFF;
  bit          use_err = 1'b0;
  bit          stall_en = 1'b0;
  bit          stall_done = 1'b0;
  int          withhold_tap = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Responder: zero-wait ready and response unless a stall or withheld tap is configured.
  initial begin
    int rtap;
    test_ready_i = 1'b1;
    resp_valid_i = 1'b0;
    resp_data_i  = '0;
    resp_error_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (stall_en && !stall_done && test_valid_o && delay_o == 4'd3) begin
        test_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
          check("stall_valid_held", {31'd0, test_valid_o}, 32'd1);
          check("stall_delay_stable", {28'd0, delay_o}, 32'd3);
          @(negedge clk_i);
        end
        test_ready_i = 1'b1;
        stall_done   = 1'b1;
      end
      if (test_valid_o && test_ready_i) begin
        rtap = int'(delay_o);
        @(posedge clk_i);
        #1;
        if (rtap != withhold_tap) begin
          resp_valid_i = 1'b1;
          if (pass_mask[rtap[3:0]]) begin
            resp_data_i  = Pattern;
            resp_error_i = 1'b0;
          end else begin
            resp_data_i  = use_err ? Pattern : 16'h0000;
            resp_error_i = use_err;
          end
          @(posedge clk_i);
          #1;
          resp_valid_i = 1'b0;
          resp_error_i = 1'b0;
          resp_data_i  = '0;
          if (stall_en && rtap == 3) begin
            // Good-looking response while the next tap settles; must be ignored.
            @(posedge clk_i);
            #1;
            resp_valid_i = 1'b1;
            resp_data_i  = Pattern;
            @(posedge clk_i);
            #1;
            resp_valid_i = 1'b0;
            resp_data_i  = '0;
          end
        end
      end
    end
  end

  task automatic run_vec(input string tag, input vec_t v);
    int cyc;
    bit seen;
    pass_mask  = v.mask;
    use_err    = v.use_err;
    stall_en   = v.stall;
    stall_done = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check({tag, "_busy_start"}, {31'd0, busy_o}, 32'd1);
    check({tag, "_fail_cleared"}, {31'd0, fail_o}, 32'd0);
    check({tag, "_delay_tap0"}, {28'd0, delay_o}, 32'd0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (done_o) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_latency"}, cyc, v.lat);
    check({tag, "_win_lo"}, {28'd0, win_lo_o}, {28'd0, v.lo});
    check({tag, "_win_len"}, {27'd0, win_len_o}, {27'd0, v.len});
    check({tag, "_delay"}, {28'd0, delay_o}, {28'd0, v.dly});
    check({tag, "_fail"}, {31'd0, fail_o}, {31'd0, v.fail});
    @(posedge clk_i);
    #1;
    check({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
    check({tag, "_idle_after"}, {31'd0, busy_o}, 32'd0);
    stall_en = 1'b0;
    repeat (3) @(posedge clk_i);
  endtask

  initial begin
    int  n;
    bit  found;
    vec_t tv;
    //          mask      err   stall lo     len     dly    fail lat
    vecs[0] = '{16'hFFFF, 1'b0, 1'b0, 4'd0,  5'd16, 4'd7,  1'b0, 129};
    vecs[1] = '{16'h07E0, 1'b0, 1'b0, 4'd5,  5'd6,  4'd7,  1'b0, 129};
    vecs[2] = '{16'h0E0E, 1'b0, 1'b0, 4'd1,  5'd3,  4'd2,  1'b0, 129};
    vecs[3] = '{16'h0000, 1'b1, 1'b0, 4'd0,  5'd0,  4'd8,  1'b1, 129};
    vecs[4] = '{16'h1000, 1'b0, 1'b0, 4'd12, 5'd1,  4'd12, 1'b0, 129};
    vecs[5] = '{16'h8000, 1'b0, 1'b0, 4'd15, 5'd1,  4'd15, 1'b0, 129};
    vecs[6] = '{16'hE000, 1'b1, 1'b0, 4'd13, 5'd3,  4'd14, 1'b0, 129};
    vecs[7] = '{16'h7FFF, 1'b0, 1'b0, 4'd0,  5'd15, 4'd7,  1'b0, 129};
    vecs[8] = '{16'h07E0, 1'b0, 1'b1, 4'd5,  5'd6,  4'd7,  1'b0, 139};

    rst_ni  = 1'b0;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_delay", {28'd0, delay_o}, 32'd8);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_fail", {31'd0, fail_o}, 32'd0);
    check("rst_valid", {31'd0, test_valid_o}, 32'd0);
    check("rst_win_lo", {28'd0, win_lo_o}, 32'd0);
    check("rst_win_len", {27'd0, win_len_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset while waiting for the tap-9 response.
    pass_mask = 16'hFFFF;
    use_err   = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    found = 1'b0;
    n     = 0;
    while (!found && n < 1000) begin
      @(negedge clk_i);
      n++;
      if (delay_o == 4'd9 && test_valid_o && test_ready_i) found = 1'b1;
    end
    check("reach_tap9_req", {31'd0, found}, 32'd1);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_delay", {28'd0, delay_o}, 32'd8);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_valid", {31'd0, test_valid_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("midrst_stays_idle", {31'd0, busy_o}, 32'd0);
    run_vec("after_rst", vecs[1]);

`ifdef HYPERBUS_TRAIN_TIMEOUT_EN
    // Tap 4 never answers: scored as a fail after 64 WAIT cycles.
    withhold_tap = 4;
    tv = '{16'hFFFF, 1'b0, 1'b0, 4'd5, 5'd11, 4'd10, 1'b0, 192};
    run_vec("timeout", tv);
    withhold_tap = -1;
`else
    tv = vecs[0];
    run_vec("final", tv);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
